// File: rtl/iwrite_stream_router_if.sv
// ---------------------------------------------------------------------------
// iwrite_stream_router_if
// Groups every bus signal of the header-driven stream router.
//   Stream in   : idata, idata_valid (to router), idata_ready (from router)
//   IBRAM write : diA, addrA, enaA, weA, ping_pong
//   INSTR sink  : idata_instr, idata_instr_valid, instr_bank_counter,
//                 idata_instr_ready (from sink)
//   PARAM sink  : param_data, param_data_valid, param_data_ready (from sink)
//   Status      : act_done, busy, err_hdr, err_ovf
// Modport slave is the router's view; modport master is the surrounding
// system (stream source plus all sinks).
// ---------------------------------------------------------------------------
interface iwrite_stream_router_if #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS    = 16,
  parameter int IBRAM_DEPTH  = 1024
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = $clog2(IBRAM_DEPTH);

  logic [STREAM_WIDTH-1:0] idata;
  logic                    idata_valid;
  logic                    idata_ready;

  logic [STREAM_WIDTH-1:0] diA;
  logic [ADDR_W-1:0]       addrA;
  logic [NUM_BANKS-1:0]    enaA;
  logic [NUM_BANKS-1:0]    weA;
  logic                    ping_pong;

  logic [STREAM_WIDTH-1:0] idata_instr;
  logic                    idata_instr_valid;
  logic [BANK_W-1:0]       instr_bank_counter;
  logic                    idata_instr_ready;

  logic [STREAM_WIDTH-1:0] param_data;
  logic                    param_data_valid;
  logic                    param_data_ready;

  logic                    act_done;
  logic                    busy;
  logic                    err_hdr;
  logic                    err_ovf;

  modport slave (
    input  idata, idata_valid, idata_instr_ready, param_data_ready,
    output idata_ready, diA, addrA, enaA, weA, ping_pong,
           idata_instr, idata_instr_valid, instr_bank_counter,
           param_data, param_data_valid, act_done, busy, err_hdr, err_ovf
  );

  modport master (
    output idata, idata_valid, idata_instr_ready, param_data_ready,
    input  idata_ready, diA, addrA, enaA, weA, ping_pong,
           idata_instr, idata_instr_valid, instr_bank_counter,
           param_data, param_data_valid, act_done, busy, err_hdr, err_ovf
  );
endinterface

// File: rtl/iwrite_stream_router.sv
// ---------------------------------------------------------------------------
// iwrite_stream_router
// Takes one AXI-Stream input and steers each packet, as announced by its
// header beat, to the parameter module, the instruction buffer or the banked
// activation IBRAM. Unknown packet types are swallowed and flagged.
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : iwrite_stream_router_if.slave (stream in, IBRAM write port,
//          INSTR and PARAM sinks, status flags)
// Header beat: [1:0] type, [LEN_WIDTH+1:2] payload length,
//              [LEN_WIDTH+2 +: log2(NUM_BANKS)] ACT start bank.
// ---------------------------------------------------------------------------
module iwrite_stream_router #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS    = 16,
  parameter int IBRAM_DEPTH  = 1024,
  parameter int LEN_WIDTH    = 16,
  parameter bit PINGPONG_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  iwrite_stream_router_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = $clog2(IBRAM_DEPTH);
  localparam logic [BANK_W-1:0]    LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(IBRAM_DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0] ONE_LEFT  = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_HDR,
    S_PARAM,
    S_INSTR,
    S_ACT,
    S_DROP
  } state_t;

  state_t                  r_state;
  logic [LEN_WIDTH-1:0]    r_remain;
  logic [ADDR_W-1:0]       r_addr;
  logic [BANK_W-1:0]       r_bank;
  logic [BANK_W-1:0]       r_instrBank;
  logic [STREAM_WIDTH-1:0] r_diA;
  logic [ADDR_W-1:0]       r_addrA;
  logic [NUM_BANKS-1:0]    r_enaA;
  logic                    r_pingPong;
  logic                    r_actDone;
  logic                    r_errHdr;
  logic                    r_errOvf;

  logic [1:0]              w_type;
  logic [LEN_WIDTH-1:0]    w_len;
  logic [BANK_W-1:0]       w_startBank;
  logic                    w_ready;
  logic                    w_hs;
  logic                    w_lastBeat;

  assign w_type      = bus.idata[1:0];
  assign w_len       = bus.idata[LEN_WIDTH+1:2];
  assign w_startBank = bus.idata[LEN_WIDTH+2 +: BANK_W];
  assign w_hs        = bus.idata_valid & w_ready;
  assign w_lastBeat  = (r_remain == ONE_LEFT);

  // Stream ready: header, ACT and DROP never stall because the IBRAM always
  // accepts a write; PARAM and INSTR hand the decision to their sink so the
  // payload flows straight through without any buffering here.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_HDR, S_ACT, S_DROP: w_ready = 1'b1;
      S_PARAM:              w_ready = bus.param_data_ready;
      S_INSTR:              w_ready = bus.idata_instr_ready;
      default:              w_ready = 1'b0;
    endcase
  end

  // Packet FSM plus every registered output. A header with LEN=0 leaves the
  // FSM in HDR so the next beat is a header again. The IBRAM write port is a
  // one-cycle pulse per accepted ACT beat; the bank walks upward from the
  // start bank and the word address only advances when the bank wraps, so
  // consecutive beats stripe across all banks. ping_pong flips on the edge
  // that closes the act_done cycle, which keeps the last write of a packet
  // in the half that the rest of the packet used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HDR;
      r_remain    <= '0;
      r_addr      <= '0;
      r_bank      <= '0;
      r_instrBank <= '0;
      r_diA       <= '0;
      r_addrA     <= '0;
      r_enaA      <= '0;
      r_pingPong  <= 1'b0;
      r_actDone   <= 1'b0;
      r_errHdr    <= 1'b0;
      r_errOvf    <= 1'b0;
    end else begin
      r_enaA    <= '0;
      r_actDone <= 1'b0;
      if (PINGPONG_EN && r_actDone) begin
        r_pingPong <= ~r_pingPong;
      end

      case (r_state)
        S_HDR: begin
          if (w_hs) begin
            r_remain <= w_len;
            if (w_type == 2'd3) begin
              r_errHdr <= 1'b1;
              if (w_len != '0) begin
                r_state <= S_DROP;
              end
            end else if (w_len != '0) begin
              case (w_type)
                2'd0: r_state <= S_PARAM;
                2'd1: begin
                  r_state     <= S_INSTR;
                  r_instrBank <= '0;
                end
                default: begin
                  r_state <= S_ACT;
                  r_addr  <= '0;
                  r_bank  <= w_startBank;
                end
              endcase
            end
          end
        end

        S_PARAM, S_DROP: begin
          if (w_hs) begin
            r_remain <= r_remain - 1'b1;
            if (w_lastBeat) begin
              r_state <= S_HDR;
            end
          end
        end

        S_INSTR: begin
          if (w_hs) begin
            r_remain    <= r_remain - 1'b1;
            r_instrBank <= (r_instrBank == LAST_BANK) ? '0 : r_instrBank + 1'b1;
            if (w_lastBeat) begin
              r_state <= S_HDR;
            end
          end
        end

        S_ACT: begin
          if (w_hs) begin
            r_diA    <= bus.idata;
            r_addrA  <= r_addr;
            r_enaA   <= NUM_BANKS'(1) << r_bank;
            r_remain <= r_remain - 1'b1;
            if (r_bank == LAST_BANK) begin
              r_bank <= '0;
              if (r_addr == LAST_ADDR) begin
                r_addr   <= '0;
                r_errOvf <= 1'b1;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end else begin
              r_bank <= r_bank + 1'b1;
            end
            if (w_lastBeat) begin
              r_actDone <= 1'b1;
              r_state   <= S_HDR;
            end
          end
        end

        default: r_state <= S_HDR;
      endcase
    end
  end

  // Sink pass-through is gated by state so no sink ever sees a header or a
  // beat that belongs to another packet type.
  assign bus.idata_ready        = w_ready;
  assign bus.param_data         = (r_state == S_PARAM) ? bus.idata : '0;
  assign bus.param_data_valid   = (r_state == S_PARAM) & bus.idata_valid;
  assign bus.idata_instr        = (r_state == S_INSTR) ? bus.idata : '0;
  assign bus.idata_instr_valid  = (r_state == S_INSTR) & bus.idata_valid;
  assign bus.instr_bank_counter = r_instrBank;
  assign bus.diA                = r_diA;
  assign bus.addrA              = r_addrA;
  assign bus.enaA               = r_enaA;
  assign bus.weA                = r_enaA;
  assign bus.ping_pong          = r_pingPong;
  assign bus.act_done           = r_actDone;
  assign bus.busy               = (r_state != S_HDR);
  assign bus.err_hdr            = r_errHdr;
  assign bus.err_ovf            = r_errOvf;
endmodule

// File: tb/tb_iwrite_stream_router.sv
// ---------------------------------------------------------------------------
// tb_iwrite_stream_router
// Drives header+payload packets into iwrite_stream_router and compares every
// sink event against queues of expected events built from the packet rules:
// PARAM beats in order, INSTR beats with bank index i mod NUM_BANKS, and ACT
// writes at bank (start+i) mod NUM_BANKS, address ((start+i) / NUM_BANKS) mod
// IBRAM_DEPTH. A small IBRAM depth keeps the overflow case short.
// ---------------------------------------------------------------------------
module tb_iwrite_stream_router;
  localparam int W  = 32;
  localparam int NB = 16;
  localparam int D  = 4;
  localparam int LW = 16;
  localparam int BW = $clog2(NB);

  typedef struct {
    logic [W-1:0] data;
    int           bank;
    int           addr;
    bit           last;
    bit           pp;
  } wrExp_t;

  typedef struct {
    logic [W-1:0] data;
    int           bank;
  } insExp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iwrite_stream_router_if #(.STREAM_WIDTH(W), .NUM_BANKS(NB), .IBRAM_DEPTH(D)) bus ();

  iwrite_stream_router #(
    .STREAM_WIDTH(W),
    .NUM_BANKS   (NB),
    .IBRAM_DEPTH (D),
    .LEN_WIDTH   (LW),
    .PINGPONG_EN (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int           nCompared   = 0;
  int           nMismatched = 0;
  bit           monOn       = 1'b0;
  bit           rndRdy      = 1'b0;
  logic [W-1:0] expPar[$];
  insExp_t      expIns[$];
  wrExp_t       expWr[$];
  logic [W-1:0] pay[$];
  bit           mdlPing   = 1'b0;
  bit           mdlErrHdr = 1'b0;
  bit           mdlErrOvf = 1'b0;
  bit           pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  wrExp_t       monWr;
  insExp_t      monIns;
  logic [W-1:0] monPar;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] makeHeader(input int typ, input int len, input int start);
    logic [W-1:0] h;
    h = W'($urandom);
    h[1:0] = 2'(typ);
    h[LW+1:2] = LW'(len);
    h[LW+2 +: BW] = BW'(start);
    return h;
  endfunction

  // Reference model: turns one packet into the sink events it must cause.
  task automatic modelPacket(input int typ, input int len, input int start);
    wrExp_t  w;
    insExp_t s;
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(W'($urandom));
    case (typ)
      0: for (int i = 0; i < len; i++) expPar.push_back(pay[i]);
      1: for (int i = 0; i < len; i++) begin
        s.data = pay[i];
        s.bank = i % NB;
        expIns.push_back(s);
      end
      2: begin
        for (int i = 0; i < len; i++) begin
          w.data = pay[i];
          w.bank = (start + i) % NB;
          w.addr = ((start + i) / NB) % D;
          w.last = (i == len - 1);
          w.pp   = mdlPing;
          expWr.push_back(w);
        end
        if (start + len > NB * D) mdlErrOvf = 1'b1;
        if (len > 0) mdlPing = ~mdlPing;
      end
      default: mdlErrHdr = 1'b1;
    endcase
  endtask

  // Offers one beat (called at posedge+1) and holds it until accepted.
  task automatic sendBeat(input logic [W-1:0] d, input bit gaps);
    bit taken = 1'b0;
    int n = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      @(posedge clk); #1;
    end
    bus.idata       = d;
    bus.idata_valid = 1'b1;
    while (!taken && n < 100) begin
      @(negedge clk);
      taken = (bus.idata_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    if (!taken) checkOutput("hs_timeout", 64'(taken), 64'(1));
    bus.idata_valid = 1'b0;
    bus.idata       = W'($urandom);
  endtask

  task automatic applyStimulus(input int typ, input int len, input int start,
                               input int nSend, input bit gaps);
    modelPacket(typ, len, start);
    sendBeat(makeHeader(typ, len, start), gaps);
    for (int i = 0; i < nSend; i++) sendBeat(pay[i], gaps);
  endtask

  task automatic drainAndCheck(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((expPar.size() + expIns.size() + expWr.size() + int'(bus.busy)) != 0 && n < 400);
    checkOutput({tag, "_pending"}, 64'(expPar.size() + expIns.size() + expWr.size()), 64'(0));
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'(0));
    checkOutput({tag, "_ping"}, 64'(bus.ping_pong), 64'(mdlPing));
    checkOutput({tag, "_err_hdr"}, 64'(bus.err_hdr), 64'(mdlErrHdr));
    checkOutput({tag, "_err_ovf"}, 64'(bus.err_ovf), 64'(mdlErrOvf));
    @(posedge clk); #1;
  endtask

  // Sink ready generator for the randomized phases.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rndRdy) begin
        bus.param_data_ready  = ($urandom_range(0, 3) != 0);
        bus.idata_instr_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Sink monitor: every observed event must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (bus.enaA !== '0) begin
          if (expWr.size() == 0) begin
            checkOutput("wr_unexpected", 64'(bus.enaA), 64'(0));
          end else begin
            monWr = expWr.pop_front();
            checkOutput("wr_enaA", 64'(bus.enaA), 64'(1) << monWr.bank);
            checkOutput("wr_weA", 64'(bus.weA), 64'(1) << monWr.bank);
            checkOutput("wr_addrA", 64'(bus.addrA), 64'(monWr.addr));
            checkOutput("wr_diA", 64'(bus.diA), 64'(monWr.data));
            checkOutput("wr_act_done", 64'(bus.act_done), 64'(monWr.last));
            checkOutput("wr_ping", 64'(bus.ping_pong), 64'(monWr.pp));
          end
        end else begin
          checkOutput("idle_weA", 64'(bus.weA), 64'(0));
          checkOutput("idle_act_done", 64'(bus.act_done), 64'(0));
        end
        if (bus.param_data_valid === 1'b1) begin
          if (expPar.size() == 0) begin
            checkOutput("par_unexpected", 64'(bus.param_data_valid), 64'(0));
          end else if (bus.param_data_ready === 1'b1) begin
            monPar = expPar.pop_front();
            checkOutput("par_data", 64'(bus.param_data), 64'(monPar));
          end
        end
        if (bus.idata_instr_valid === 1'b1) begin
          if (expIns.size() == 0) begin
            checkOutput("ins_unexpected", 64'(bus.idata_instr_valid), 64'(0));
          end else if (bus.idata_instr_ready === 1'b1) begin
            monIns = expIns.pop_front();
            checkOutput("ins_data", 64'(bus.idata_instr), 64'(monIns.data));
            checkOutput("ins_bank", 64'(bus.instr_bank_counter), 64'(monIns.bank));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    nMismatched++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    int typ, len, start, beat;
    bus.idata             = '0;
    bus.idata_valid       = 1'b1;
    bus.param_data_ready  = 1'b1;
    bus.idata_instr_ready = 1'b1;
    rst = 1'b1;

    // Reset held two cycles with a valid beat present.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_idata_ready", 64'(bus.idata_ready), 64'(1));
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_enaA", 64'(bus.enaA), 64'(0));
    checkOutput("rst_weA", 64'(bus.weA), 64'(0));
    checkOutput("rst_addrA", 64'(bus.addrA), 64'(0));
    checkOutput("rst_diA", 64'(bus.diA), 64'(0));
    checkOutput("rst_ping", 64'(bus.ping_pong), 64'(0));
    checkOutput("rst_act_done", 64'(bus.act_done), 64'(0));
    checkOutput("rst_err_hdr", 64'(bus.err_hdr), 64'(0));
    checkOutput("rst_err_ovf", 64'(bus.err_ovf), 64'(0));
    checkOutput("rst_instr_bank", 64'(bus.instr_bank_counter), 64'(0));
    checkOutput("rst_par_valid", 64'(bus.param_data_valid), 64'(0));
    checkOutput("rst_ins_valid", 64'(bus.idata_instr_valid), 64'(0));
    checkOutput("rst_par_data", 64'(bus.param_data), 64'(0));
    checkOutput("rst_ins_data", 64'(bus.idata_instr), 64'(0));
    @(posedge clk); #1;
    rst             = 1'b0;
    bus.idata_valid = 1'b0;
    monOn           = 1'b1;

    // ACT from start bank 14, 20 beats: banks wrap twice, addr 0,1,2.
    applyStimulus(2, 20, 14, 20, 1'b0);
    drainAndCheck("act20");

    // PARAM with a scripted sink ready, then a zero-bubble INSTR header.
    modelPacket(0, 3, 0);
    sendBeat(makeHeader(0, 3, 0), 1'b0);
    beat = 0;
    for (int k = 0; k < 5; k++) begin
      bus.param_data_ready = pat[k];
      bus.idata            = pay[beat];
      bus.idata_valid      = 1'b1;
      @(negedge clk);
      checkOutput("par_ready_mirror", 64'(bus.idata_ready), 64'(pat[k]));
      @(posedge clk); #1;
      if (pat[k]) beat++;
    end
    fork
      begin
        @(negedge clk);
        checkOutput("b2b_hdr_ready", 64'(bus.idata_ready), 64'(1));
        checkOutput("b2b_busy", 64'(bus.busy), 64'(0));
        checkOutput("par_hs_count", 64'(expPar.size()), 64'(0));
      end
    join_none
    rndRdy = 1'b1;
    applyStimulus(1, 18, 0, 18, 1'b0);
    drainAndCheck("instr18");

    // Reserved type: payload swallowed, sticky header error.
    applyStimulus(3, 2, 0, 2, 1'b1);
    drainAndCheck("drop");

    // Randomized packet mix with random gaps and sink back-pressure.
    for (int p = 0; p < 40; p++) begin
      typ   = $urandom_range(0, 3);
      len   = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 20);
      start = $urandom_range(0, NB - 1);
      applyStimulus(typ, len, start, len, 1'b1);
      if (p % 10 == 9) drainAndCheck("rand");
    end

    // ACT one beat past the full IBRAM half: address wraps to 0.
    applyStimulus(2, NB * D + 1, 0, NB * D + 1, 1'b0);
    drainAndCheck("ovf");

    // Reset after 5 of 10 ACT beats.
    applyStimulus(2, 10, 3, 5, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expPar.delete();
    expIns.delete();
    expWr.delete();
    mdlPing   = 1'b0;
    mdlErrHdr = 1'b0;
    mdlErrOvf = 1'b0;
    @(negedge clk);
    checkOutput("midrst_enaA", 64'(bus.enaA), 64'(0));
    checkOutput("midrst_ping", 64'(bus.ping_pong), 64'(0));
    checkOutput("midrst_busy", 64'(bus.busy), 64'(0));
    checkOutput("midrst_err_ovf", 64'(bus.err_ovf), 64'(0));
    @(posedge clk); #1;
    applyStimulus(1, 3, 0, 3, 1'b0);
    drainAndCheck("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/iwrite_stream_router.md
Name: iwrite_stream_router

Overview:
- Header-driven successor of the input write controller.
- Accepts one AXI-Stream input and steers each packet to one of three sinks:
  - the parameter module (PARAM),
  - the instruction buffer (INSTR),
  - the banked activation IBRAM (ACT).
- Bank count, stream width and BRAM depth are parametrised. Adds ping-pong activation buffering, start-bank selection and sticky error reporting.

Parameters:
- STREAM_WIDTH, 128, width of stream beats, instruction and IBRAM data.
- NUM_BANKS, 16, number of IBRAM banks (power of 2, >=2).
- IBRAM_DEPTH, 1024, words per bank per ping-pong half (power of 2).
- LEN_WIDTH, 16, width of the header payload-length field.
- PINGPONG_EN, 1, 1: ping_pong toggles after each completed ACT packet; 0: ping_pong held at 0.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- idata  in  STREAM_WIDTH  stream data.
- idata_valid  in  1  stream valid.
- idata_ready  out  1  stream ready.
- diA  out  STREAM_WIDTH  IBRAM write data.
- addrA  out  $clog2(IBRAM_DEPTH)  IBRAM write address.
- enaA  out  NUM_BANKS  one-hot bank enable.
- weA  out  NUM_BANKS  one-hot bank write enable (equal to enaA).
- ping_pong  out  1  active IBRAM half for writes.
- idata_instr  out  STREAM_WIDTH  instruction data.
- idata_instr_valid  out  1  instruction valid.
- instr_bank_counter  out  $clog2(NUM_BANKS)  target instruction bank.
- idata_instr_ready  in  1  instruction ready.
- param_data  out  STREAM_WIDTH  parameter data.
- param_data_valid  out  1  parameter valid.
- param_data_ready  in  1  parameter ready.
- act_done  out  1  one-cycle pulse when the last ACT beat is written.
- busy  out  1  high whenever the state is not HDR.
- err_hdr  out  1  sticky: header with reserved type seen.
- err_ovf  out  1  sticky: ACT address wrapped past IBRAM_DEPTH-1.

Behaviour:
- Reset (rst=1 at an edge): state=HDR. All outputs are 0, including ping_pong, the sticky errors, addrA and instr_bank_counter. Reset mid-packet discards the remainder; the next accepted beat is treated as a header.
- Header beat fields:
  - type = idata[1:0]: 0 PARAM, 1 INSTR, 2 ACT, 3 reserved.
  - LEN = idata[LEN_WIDTH+1:2], number of payload beats.
  - start_bank = idata[LEN_WIDTH+2 +: $clog2(NUM_BANKS)].
- States:
  - HDR: idata_ready=1. On handshake, latch type/LEN/start_bank.
    - LEN=0 with a valid type: stay in HDR, no sink activity. For ACT there is no act_done and no ping_pong toggle.
    - type=3: set err_hdr and enter DROP with LEN.
    - Otherwise enter PARAM, INSTR or ACT. For ACT: addr<=0, bank<=start_bank. For INSTR: instr_bank_counter<=0.
  - PARAM: combinational pass-through.
    - param_data=idata, param_data_valid=idata_valid, idata_ready=param_data_ready.
    - Each handshake decrements the remaining count; at 1->0 return to HDR.
  - INSTR: same pass-through to the idata_instr ports.
    - instr_bank_counter increments after each accepted beat and wraps NUM_BANKS-1 -> 0.
  - ACT: idata_ready=1; the BRAM never stalls.
    - On handshake, at the next edge: diA<=idata, addrA<=addr, enaA=weA<=one-hot(bank). Write latency is 1 cycle.
    - enaA/weA are 0 in every cycle with no registered write.
    - Bank advances by 1 per beat. On wrap NUM_BANKS-1 -> 0, addr increments.
    - addr wrap IBRAM_DEPTH-1 -> 0 sets err_ovf; writing continues.
    - Last beat: act_done=1 in the same cycle as its enaA. If PINGPONG_EN=1, ping_pong toggles at that edge, so the last write still uses the old half. Return to HDR.
  - DROP: idata_ready=1. Consume LEN beats with no sink activity, then HDR. LEN=0 returns to HDR immediately.
- Sink valid outputs are never asserted outside their own state. Sink data is don't-care when its valid=0.
- The header is never forwarded to any sink.
- Back-to-back packets are allowed with zero bubble: the header beat is accepted in the cycle after the last payload handshake.
- Sticky errors clear only on rst.

Test Plan:
- Reset: hold rst 2 cycles with idata_valid=1 -> idata_ready=1 in HDR; all other outputs 0; busy=0.
- ACT, NUM_BANKS=16, header type=2 LEN=20 start_bank=14:
  - 20 writes, banks 14,15,0..15,0,1.
  - addrA=0 for the first two beats, 1 for the next 16, 2 for the last two.
  - act_done on the 20th write; ping_pong 0 -> 1 after it.
- PARAM, type=0 LEN=3, param_data_ready toggled 1,0,0,1,1:
  - exactly 3 param handshakes, in order.
  - idata_ready mirrors param_data_ready.
  - the next header is accepted the following cycle.
- INSTR, type=1 LEN=18 -> instr_bank_counter sequence 0..15,0,1; the header is never seen on idata_instr.
- Error paths:
  - type=3 LEN=2 -> err_hdr=1; 2 beats dropped with no sink activity.
  - ACT LEN=IBRAM_DEPTH*NUM_BANKS+1 -> err_ovf=1; the last write goes to addrA=0.
- Reset mid-ACT after 5 of 10 beats:
  - enaA=0 from the reset cycle on; ping_pong=0.
  - the next beat is decoded as a header.
